uart_rx_os: RTL

// - 16x-oversampled UART receiver, the counterpart of uart_tx on the far end of the serial link.
// - Synchronises the async rx line, qualifies the start bit and samples each bit at mid-period.
// - Delivers bytes through a one-entry valid/ready holding register.
// - Reports framing, parity and overrun errors to the host-side logic.

---
 rtl/uart_rx_os.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// 16x-oversampled UART receiver with a one-entry valid/ready holding register.
// Optional parity check enabled by defining UART_RX_PARITY_EN (PARITY_ODD selects odd/even).
module uart_rx_os #(
    parameter int unsigned clk_freq   = 50000000,
    parameter int unsigned baud_rate  = 19200,
    parameter int unsigned oversample = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int unsigned DIV   = clk_freq / (baud_rate * oversample);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(oversample);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(oversample / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(oversample - 1);

    if (DIV < 1 || oversample < 8 || (oversample % 2) != 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_os: need DIV >= 1, even oversample >= 8, PARITY_ODD in {0,1}");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_prev;
    logic [DIV_W-1:0] r_div_cnt;
    logic [OS_W-1:0]  r_os_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_busy;

    logic             w_tick;
    logic             w_mid;
    logic             w_sample;
    logic             w_par_bad;

    assign w_tick   = (r_div_cnt == DIV_LAST);
    assign w_mid    = w_tick && (r_os_cnt == OS_MID);
    assign w_sample = w_tick && (r_os_cnt == OS_LAST);

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;

    // Data bits XOR parity bit must equal 1 for odd parity, 0 for even.
    assign w_par_bad  = ((^r_shift) ^ r_par_bit) != 1'(PARITY_ODD);
    assign parity_err = r_parity_err;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign rx_data_out = r_data;
    assign rx_valid    = r_valid;
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;
    assign rx_busy     = r_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_div_cnt   <= '0;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_meta   <= rx;
            r_rx_s      <= r_rx_meta;
            r_rx_prev   <= r_rx_s;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif

            // Free-running tick and sample counters; START entry overrides below.
            if (w_tick) begin
                r_div_cnt <= '0;
                r_os_cnt  <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_rx_prev && !r_rx_s) begin
                        r_state   <= S_START;
                        r_busy    <= 1'b1;
                        r_div_cnt <= '0;
                        r_os_cnt  <= '0;
                    end
                end
                S_START: begin
                    if (w_mid) begin
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            // Sample phase is now mid-bit; later samples fall every oversample ticks.
                            r_state   <= S_DATA;
                            r_os_cnt  <= '0;
                            r_bit_cnt <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_sample) begin
                        r_par_bit <= r_rx_s;
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_sample) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
                        end else if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= 1'b1;
`endif
                        end else if (!r_valid || rx_ready) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
